// File: rtl/iir_biquad_cascade_tdm_if.sv
// Streaming sample interface for the biquad cascade: sample input (s_*) and filtered output (m_*).
// The filter uses the slave view; the sample source/sink uses the master view.
interface iir_biquad_cascade_tdm_if #(
  parameter int DATA_W = 12
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;
  logic                     m_valid;
  logic                     m_ready;
  logic signed [DATA_W-1:0] m_data;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );
endinterface

// File: rtl/iir_biquad_cascade_tdm.sv
// Cascade of Direct-Form-I biquads sharing one multiplier; five MAC cycles plus one writeback per stage.
// Runtime stage count (0 = bypass), rounding + saturation per stage, sticky saturation flag.
//
// state  | meaning
// IDLE   | ready for a sample; clear_state zeroes all delay lines instead of accepting
// MAC    | five taps b0,b1,b2,a1,a2 of the current stage, one product per cycle
// WB     | round/saturate, shift delay line of the current stage, advance or finish
// OUT    | hold m_data with m_valid until the sink takes it
module iir_biquad_cascade_tdm #(
  parameter int STAGE_CNT  = 8,
  parameter int DATA_W     = 12,
  parameter int COEFF_W    = 16,
  parameter int COEFF_FRAC = 14,
  parameter int ACC_W      = DATA_W + COEFF_W + 3
) (
  input  logic                              clk_i,
  input  logic                              rst_n_i,
  input  logic [STAGE_CNT-1:0][COEFF_W-1:0] coeff_b0_i,
  input  logic [STAGE_CNT-1:0][COEFF_W-1:0] coeff_b1_i,
  input  logic [STAGE_CNT-1:0][COEFF_W-1:0] coeff_b2_i,
  input  logic [STAGE_CNT-1:0][COEFF_W-1:0] coeff_a1_i,
  input  logic [STAGE_CNT-1:0][COEFF_W-1:0] coeff_a2_i,
  input  logic [$clog2(STAGE_CNT+1)-1:0]    num_stages_i,
  input  logic                              clear_state_i,
  input  logic                              sat_clr_i,
  output logic                              sat_flag_o,
  iir_biquad_cascade_tdm_if.slave           stream
);

  localparam int NW = $clog2(STAGE_CNT + 1);
  localparam int SW = (STAGE_CNT > 1) ? $clog2(STAGE_CNT) : 1;
  localparam int PW = DATA_W + COEFF_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic [2:0] TAP_LAST = 3'd4;

  localparam logic signed [ACC_W-1:0] RND   = ACC_W'(2 ** (COEFF_FRAC - 1));
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  typedef logic signed [DATA_W-1:0] smp_t;

  logic [1:0]              state_q, state_d;
  logic [2:0]              tap_q, tap_d;
  logic [SW-1:0]           st_q, st_d;
  logic [NW-1:0]           n_q, n_d;
  smp_t                    xin_q, xin_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  smp_t                    m_data_q, m_data_d;
  logic                    sat_q, sat_d;

  smp_t x1_q [STAGE_CNT];
  smp_t x2_q [STAGE_CNT];
  smp_t y1_q [STAGE_CNT];
  smp_t y2_q [STAGE_CNT];
  smp_t x1_d [STAGE_CNT];
  smp_t x2_d [STAGE_CNT];
  smp_t y1_d [STAGE_CNT];
  smp_t y2_d [STAGE_CNT];

  logic [2:0]                tap_sel;
  smp_t                      mul_a;
  logic signed [COEFF_W-1:0] mul_b;
  logic signed [PW-1:0]      prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_base;
  logic signed [ACC_W-1:0]   acc_rnd;
  logic signed [ACC_W-1:0]   acc_sh;
  smp_t                      y_sat;
  logic                      y_clip;
  logic                      wb_clip;
  logic [NW-1:0]             n_clamp;
  logic                      accept;
  logic                      last_stage;

  assign stream.s_ready = rst_n_i & (state_q == S_IDLE) & ~clear_state_i;
  assign stream.m_valid = (state_q == S_OUT);
  assign stream.m_data  = m_data_q;
  assign sat_flag_o     = sat_q;

  assign accept     = stream.s_valid & stream.s_ready;
  assign n_clamp    = (num_stages_i > NW'(STAGE_CNT)) ? NW'(STAGE_CNT) : num_stages_i;
  assign last_stage = ((NW'(st_q) + NW'(1)) == n_q);

  // Shared multiplier: tap_q counts down 4..0, so tap_sel walks b0,b1,b2,a1,a2.
  always_comb begin
    tap_sel = TAP_LAST - tap_q;
    mul_a   = xin_q;
    mul_b   = coeff_b0_i[st_q];
    case (tap_sel)
      3'd1: begin
        mul_a = x1_q[st_q];
        mul_b = coeff_b1_i[st_q];
      end
      3'd2: begin
        mul_a = x2_q[st_q];
        mul_b = coeff_b2_i[st_q];
      end
      3'd3: begin
        mul_a = y1_q[st_q];
        mul_b = coeff_a1_i[st_q];
      end
      3'd4: begin
        mul_a = y2_q[st_q];
        mul_b = coeff_a2_i[st_q];
      end
      default: ;
    endcase
    prod     = PW'(mul_a) * PW'(mul_b);
    prod_ext = ACC_W'(prod);
    acc_base = (tap_q == TAP_LAST) ? '0 : acc_q;
  end

  always_comb begin
    acc_rnd = acc_q + RND;
    acc_sh  = acc_rnd >>> COEFF_FRAC;
    y_clip  = (acc_sh > Y_MAX) || (acc_sh < Y_MIN);
    if (acc_sh > Y_MAX)      y_sat = Y_MAX[DATA_W-1:0];
    else if (acc_sh < Y_MIN) y_sat = Y_MIN[DATA_W-1:0];
    else                     y_sat = acc_sh[DATA_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    st_d     = st_q;
    n_d      = n_q;
    xin_d    = xin_q;
    acc_d    = acc_q;
    m_data_d = m_data_q;
    x1_d     = x1_q;
    x2_d     = x2_q;
    y1_d     = y1_q;
    y2_d     = y2_q;
    wb_clip  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clear_state_i) begin
          for (int i = 0; i < STAGE_CNT; i++) begin
            x1_d[i] = '0;
            x2_d[i] = '0;
            y1_d[i] = '0;
            y2_d[i] = '0;
          end
        end else if (accept) begin
          xin_d = stream.s_data;
          n_d   = n_clamp;
          st_d  = '0;
          tap_d = TAP_LAST;
          if (n_clamp == '0) begin
            m_data_d = stream.s_data;
            state_d  = S_OUT;
          end else begin
            state_d = S_MAC;
          end
        end
      end

      S_MAC: begin
        // Feedback taps carry the minus sign of the difference equation.
        acc_d = (tap_sel >= 3'd3) ? (acc_base - prod_ext) : (acc_base + prod_ext);
        if (tap_q == '0) state_d = S_WB;
        else             tap_d   = tap_q - 3'd1;
      end

      S_WB: begin
        x2_d[st_q] = x1_q[st_q];
        x1_d[st_q] = xin_q;
        y2_d[st_q] = y1_q[st_q];
        y1_d[st_q] = y_sat;
        xin_d      = y_sat;
        wb_clip    = y_clip;
        if (last_stage) begin
          m_data_d = y_sat;
          state_d  = S_OUT;
        end else begin
          st_d    = st_q + SW'(1);
          tap_d   = TAP_LAST;
          state_d = S_MAC;
        end
      end

      S_OUT: begin
        if (stream.m_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    sat_d = sat_clr_i ? 1'b0 : (sat_q | wb_clip);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      tap_q    <= '0;
      st_q     <= '0;
      n_q      <= '0;
      xin_q    <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      sat_q    <= 1'b0;
      for (int i = 0; i < STAGE_CNT; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      st_q     <= st_d;
      n_q      <= n_d;
      xin_q    <= xin_d;
      acc_q    <= acc_d;
      m_data_q <= m_data_d;
      sat_q    <= sat_d;
      x1_q     <= x1_d;
      x2_q     <= x2_d;
      y1_q     <= y1_d;
      y2_q     <= y2_d;
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade_tdm.sv
// Directed bench for the biquad cascade: reset, identity, bypass, recursion, saturation,
// stage-count clamp, backpressure and delay-line clear, all against hand-computed values.
module tb_iir_biquad_cascade_tdm;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [7:0][15:0]    b0, b1, b2, a1, a2;
  logic [3:0]          num_stages;
  logic                clear_state;
  logic                sat_clr;
  logic                sat_flag;

  int n_vec = 0;
  int n_err = 0;

  iir_biquad_cascade_tdm_if #(.DATA_W(12)) bus ();

  iir_biquad_cascade_tdm dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .coeff_b0_i   (b0),
    .coeff_b1_i   (b1),
    .coeff_b2_i   (b2),
    .coeff_a1_i   (a1),
    .coeff_a2_i   (a2),
    .num_stages_i (num_stages),
    .clear_state_i(clear_state),
    .sat_clr_i    (sat_clr),
    .sat_flag_o   (sat_flag),
    .stream       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [11:0] x);
    int guard;
    guard = 0;
    bus.s_data  = x;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    bus.s_valid = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic signed [11:0] x,
                      input logic signed [11:0] y_exp, input int lat_exp);
    int lat;
    send(x);
    lat = 1;
    while (!bus.m_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, lat_exp);
    chk({tag, "_data"}, bus.m_data, y_exp);
    tick();
    chk({tag, "_mvdrop"}, bus.m_valid, 0);
  endtask

  initial begin
    int lat;
    logic ok;
    logic signed [11:0] imp_in  [6];
    logic signed [11:0] imp_out [6];
    imp_in  = '{12'sd1000, 12'sd0, 12'sd0, 12'sd0, 12'sd0, 12'sd0};
    imp_out = '{12'sd1000, 12'sd500, 12'sd250, 12'sd125, 12'sd63, 12'sd32};

    rst_n       = 1'b0;
    b0          = '0;
    b1          = '0;
    b2          = '0;
    a1          = '0;
    a2          = '0;
    num_stages  = 4'd0;
    clear_state = 1'b0;
    sat_clr     = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    tick();
    tick();
    chk("rst_mvalid", bus.m_valid, 0);
    chk("rst_mdata", bus.m_data, 0);
    chk("rst_sready", bus.s_ready, 0);
    chk("rst_sat", sat_flag, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_sready_rel", bus.s_ready, 1);

    // reset in the middle of a sample discards it
    num_stages = 4'd1;
    b0[0]      = 16'd16384;
    send(12'sd77);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    chk("t1_mvalid", bus.m_valid, 0);
    chk("t1_mdata", bus.m_data, 0);
    chk("t1_sready", bus.s_ready, 0);
    chk("t1_sat", sat_flag, 0);
    rst_n = 1'b1;
    tick();
    chk("t1_sready_rel", bus.s_ready, 1);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.m_valid) ok = 1'b0;
    end
    chk("t1_no_output", ok, 1);

    // identity stage
    xfer("t2", 12'sd100, 12'sd100, 7);

    // bypass leaves stage 0 history alone
    num_stages = 4'd0;
    xfer("t3", -12'sd5, -12'sd5, 1);
    chk("t3_y1_0", dut.y1_q[0], 100);
    chk("t3_x1_0", dut.x1_q[0], 100);

    // first-order recursion y = x + 0.5*y1
    num_stages  = 4'd1;
    a1[0]       = 16'hE000;
    clear_state = 1'b1;
    tick();
    chk("t4_clr_sready", bus.s_ready, 0);
    clear_state = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) xfer($sformatf("t4_%0d", i), imp_in[i], imp_out[i], 7);
    chk("t4_sat", sat_flag, 0);

    // saturation through two stages
    a1[0]      = '0;
    b0[0]      = 16'd32767;
    b0[1]      = 16'd32767;
    num_stages = 4'd2;
    xfer("t5_pos", 12'sd2047, 12'sd2047, 13);
    chk("t5_sat_set", sat_flag, 1);
    tick();
    tick();
    tick();
    chk("t5_sat_sticky", sat_flag, 1);
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    chk("t5_sat_clr", sat_flag, 0);
    xfer("t5_neg", -12'sd2048, -12'sd2048, 13);
    chk("t5_sat_neg", sat_flag, 1);

    // stage count above STAGE_CNT clamps to 8 identity stages
    for (int i = 0; i < 8; i++) begin
      b0[i] = 16'd16384;
      a1[i] = '0;
    end
    num_stages = 4'd15;
    xfer("t5_clamp", 12'sd300, 12'sd300, 49);

    // backpressure
    b0         = '0;
    b0[0]      = 16'd16384;
    num_stages = 4'd1;
    bus.m_ready = 1'b0;
    send(12'sd321);
    lat = 1;
    while (!bus.m_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk("t6_lat", lat, 7);
    bus.s_data  = 12'sd55;
    bus.s_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.m_data != 12'sd321 || !bus.m_valid || bus.s_ready) ok = 1'b0;
    end
    chk("t6_hold", ok, 1);
    chk("t6_data", bus.m_data, 321);
    chk("t6_sready", bus.s_ready, 0);
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    tick();
    chk("t6_mvdrop", bus.m_valid, 0);
    chk("t6_sready_idle", bus.s_ready, 1);

    // clear then rerun recursion: history must start from zero
    a1[0]       = 16'hE000;
    clear_state = 1'b1;
    tick();
    clear_state = 1'b0;
    tick();
    xfer("t6_r0", 12'sd1000, 12'sd1000, 7);
    xfer("t6_r1", 12'sd0, 12'sd500, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
